// File: rtl/vga_pat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pat_pkg
// Purpose  : Shared definitions for the VGA test-pattern generator:
//            RGB565 colour constants, 2-bit mode encodings, palette index
//            width and the palette lookup function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_pat_pkg;

   localparam int IDX_W = 3;

   localparam logic [15:0] RGB_BLACK  = 16'h0000;
   localparam logic [15:0] RGB_RED    = 16'hF800;
   localparam logic [15:0] RGB_ORANGE = 16'hFC00;
   localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
   localparam logic [15:0] RGB_GREEN  = 16'h07E0;
   localparam logic [15:0] RGB_CYAN   = 16'h07FF;
   localparam logic [15:0] RGB_BLUE   = 16'h001F;
   localparam logic [15:0] RGB_PURPLE = 16'hF81F;
   localparam logic [15:0] RGB_WHITE  = 16'hFFFF;

   localparam logic [1:0] MODE_VBAR   = 2'd0;
   localparam logic [1:0] MODE_HBAR   = 2'd1;
   localparam logic [1:0] MODE_CHECK  = 2'd2;
   localparam logic [1:0] MODE_SCROLL = 2'd3;

   localparam logic [IDX_W-1:0] IDX_WHITE = 3'd7;

   function automatic logic [15:0] pal_lookup(input logic [IDX_W-1:0] idx);
      logic [15:0] rgb;
      case (idx)
         3'd0:    rgb = RGB_RED;
         3'd1:    rgb = RGB_ORANGE;
         3'd2:    rgb = RGB_YELLOW;
         3'd3:    rgb = RGB_GREEN;
         3'd4:    rgb = RGB_CYAN;
         3'd5:    rgb = RGB_BLUE;
         3'd6:    rgb = RGB_PURPLE;
         default: rgb = RGB_WHITE;
      endcase
      return rgb;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pat_palette.sv
`default_nettype none
// ============================================================================
// Module   : vga_pat_palette
// Purpose  : Second pipeline stage. Converts the registered palette index and
//            active flag into a registered RGB565 pixel. An inactive flag
//            yields BLACK without consulting the palette.
// Ports    : vga_clk    - pixel clock
//            rst_n      - asynchronous active-low reset
//            idx_i      - palette index from stage 1
//            act_i      - pixel active flag from stage 1
//            pix_data_o - registered RGB565 pixel
// Revision : 1.0 - initial release
// ============================================================================
module vga_pat_palette
   import vga_pat_pkg::*;
(
   input  logic             vga_clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             act_i,
   output logic [15:0]      pix_data_o
);

   logic [15:0] pix_d;
   logic [15:0] pix_q;

   assign pix_d = act_i ? pal_lookup(idx_i) : RGB_BLACK;

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q <= RGB_BLACK;
      end else begin
         pix_q <= pix_d;
      end
   end

   assign pix_data_o = pix_q;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen
// Purpose  : Parametrised test-pattern pixel source with four runtime modes
//            (vertical bars, horizontal bars, checkerboard, scrolling bars),
//            a 2-stage pipeline, frame-synchronous mode switching and a
//            per-frame scroll offset.
// Ports    : vga_clk    - pixel clock
//            rst_n      - asynchronous active-low reset
//            pix_x      - current column (10'h3FF outside active area)
//            pix_y      - current row    (10'h3FF outside active area)
//            mode_i     - requested mode, loaded on the frame tick
//            cur_mode   - mode currently applied
//            frame_tick - one-cycle registered pulse after the last active px
//            pix_data   - RGB565 pixel, 2 cycles after pix_x/pix_y
// Macro    : VGA_PAT_BORDER_EN - when defined, the outermost ring of active
//            pixels is forced WHITE in every mode.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pattern_gen
   import vga_pat_pkg::*;
#(
   parameter int H_VALID     = 640,
   parameter int V_VALID     = 480,
   parameter int BAR_NUM     = 8,
   parameter int CHK_LOG2    = 5,
   parameter int SCROLL_STEP = 2
)(
   input  logic        vga_clk,
   input  logic        rst_n,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic [1:0]  mode_i,
   output logic [1:0]  cur_mode,
   output logic        frame_tick,
   output logic [15:0] pix_data
);

   generate
      if (BAR_NUM < 1 || BAR_NUM > 8) begin : g_bad_bar_num
         $error("vga_pattern_gen: BAR_NUM must be in 1..8");
      end
   endgenerate

   localparam int BAR_W = H_VALID / BAR_NUM;
   localparam int BAR_H = V_VALID / BAR_NUM;

   // ------------------------------------------------------------------
   // Frame tick, mode and scroll-offset registers
   // ------------------------------------------------------------------
   logic        tick_d,     tick_q;
   logic [1:0]  cur_mode_d, cur_mode_q;
   logic [10:0] offset_d,   offset_q;
   logic [10:0] w_off_sum;

   assign tick_d = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

   // Mode only changes on the tick, which falls after the last active pixel,
   // so a frame is always drawn in a single mode.
   assign cur_mode_d = tick_q ? mode_i : cur_mode_q;

   // Offset advances with the mode that was in force for the finished frame.
   assign w_off_sum = offset_q + 11'(SCROLL_STEP);
   always_comb begin
      offset_d = offset_q;
      if (tick_q && (cur_mode_q == MODE_SCROLL)) begin
         offset_d = (w_off_sum >= 11'(H_VALID)) ? (w_off_sum - 11'(H_VALID))
                                                : w_off_sum;
      end
   end

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q     <= 1'b0;
         cur_mode_q <= MODE_VBAR;
         offset_q   <= '0;
      end else begin
         tick_q     <= tick_d;
         cur_mode_q <= cur_mode_d;
         offset_q   <= offset_d;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: coordinate -> palette index + active flag
   // ------------------------------------------------------------------
   logic             w_active;
   logic [10:0]      w_sx_sum;
   logic [10:0]      w_sx;
   logic [10:0]      w_hcoord;
   logic [10:0]      w_vcoord;
   logic [BAR_NUM-1:0] w_ge_h;
   logic [BAR_NUM-1:0] w_ge_v;
   logic [IDX_W-1:0] w_idx_h;
   logic [IDX_W-1:0] w_idx_v;
   logic [IDX_W-1:0] idx_d, idx_q;
   logic             act_d, act_q;

   assign w_active = (pix_x < 10'(H_VALID)) && (pix_y < 10'(V_VALID));

   // Both operands are below H_VALID when active, so one conditional
   // subtract brings the sum back into range without overflowing 11 bits.
   assign w_sx_sum = {1'b0, pix_x} + offset_q;
   assign w_sx     = (w_sx_sum >= 11'(H_VALID)) ? (w_sx_sum - 11'(H_VALID))
                                                : w_sx_sum;

   assign w_hcoord = (cur_mode_q == MODE_SCROLL) ? w_sx : {1'b0, pix_x};
   assign w_vcoord = {1'b0, pix_y};

   // Threshold compare chain replaces a divider; bar 0 always matches.
   for (genvar i = 0; i < BAR_NUM; i++) begin : g_bar_cmp
      if (i == 0) begin : g_first
         assign w_ge_h[i] = 1'b1;
         assign w_ge_v[i] = 1'b1;
      end else begin : g_rest
         assign w_ge_h[i] = (w_hcoord >= 11'(i * BAR_W));
         assign w_ge_v[i] = (w_vcoord >= 11'(i * BAR_H));
      end
   end

   // Highest matching threshold wins; remainder pixels past the last
   // threshold therefore stay in the last bar.
   always_comb begin
      w_idx_h = '0;
      w_idx_v = '0;
      for (int i = 0; i < BAR_NUM; i++) begin
         if (w_ge_h[i]) w_idx_h = IDX_W'(i);
         if (w_ge_v[i]) w_idx_v = IDX_W'(i);
      end
   end

`ifdef VGA_PAT_BORDER_EN
   logic w_border;
   assign w_border = w_active &&
                     ((pix_x == 10'd0) || (pix_x == 10'(H_VALID - 1)) ||
                      (pix_y == 10'd0) || (pix_y == 10'(V_VALID - 1)));
`endif

   always_comb begin
      idx_d = w_idx_h;
      act_d = w_active;
      case (cur_mode_q)
         MODE_HBAR: begin
            idx_d = w_idx_v;
         end
         MODE_CHECK: begin
            // Dark cells clear the active flag so stage 2 emits BLACK.
            idx_d = IDX_WHITE;
            act_d = w_active & (pix_x[CHK_LOG2] ^ pix_y[CHK_LOG2]);
         end
         default: begin
         end
      endcase
`ifdef VGA_PAT_BORDER_EN
      if (w_border) begin
         idx_d = IDX_WHITE;
         act_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         act_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         act_q <= act_d;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: palette lookup
   // ------------------------------------------------------------------
   vga_pat_palette u_palette (
      .vga_clk    (vga_clk),
      .rst_n      (rst_n),
      .idx_i      (idx_q),
      .act_i      (act_q),
      .pix_data_o (pix_data)
   );

   assign cur_mode   = cur_mode_q;
   assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_gen
// Purpose  : Self-checking bench for vga_pattern_gen. Two instances share the
//            stimulus: BAR_NUM=8 and BAR_NUM=6. Expected pixels come from a
//            division-based reference model and are queued when driven, then
//            compared two cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

   localparam int H    = 640;
   localparam int V    = 480;
   localparam int STEP = 2;
   localparam int IDLE = 1023;

   logic        vga_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic [9:0]  pix_x   = 10'h3FF;
   logic [9:0]  pix_y   = 10'h3FF;
   logic [1:0]  mode_i  = 2'd0;
   logic [1:0]  cm_a, cm_b;
   logic        ft_a, ft_b;
   logic [15:0] pd_a, pd_b;

   always #5 vga_clk = ~vga_clk;

   vga_pattern_gen #(.H_VALID(H), .V_VALID(V), .BAR_NUM(8), .CHK_LOG2(5),
                     .SCROLL_STEP(STEP)) u_dut8 (
      .vga_clk(vga_clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
      .mode_i(mode_i), .cur_mode(cm_a), .frame_tick(ft_a), .pix_data(pd_a));

   vga_pattern_gen #(.H_VALID(H), .V_VALID(V), .BAR_NUM(6), .CHK_LOG2(5),
                     .SCROLL_STEP(STEP)) u_dut6 (
      .vga_clk(vga_clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
      .mode_i(mode_i), .cur_mode(cm_b), .frame_tick(ft_b), .pix_data(pd_b));

   typedef struct {
      logic [15:0] ea;
      logic [15:0] eb;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   m_mode   = 0;
   int   m_off    = 0;

   function automatic logic [15:0] pal(input int i);
      case (i)
         0:       return 16'hF800;
         1:       return 16'hFC00;
         2:       return 16'hFFE0;
         3:       return 16'h07E0;
         4:       return 16'h07FF;
         5:       return 16'h001F;
         6:       return 16'hF81F;
         default: return 16'hFFFF;
      endcase
   endfunction

   function automatic logic [15:0] ref_pix(input int x, input int y,
                                           input int mode, input int off,
                                           input int bn);
      int bw = H / bn;
      int bh = V / bn;
      int idx;
      if (x >= H || y >= V) return 16'h0000;
`ifdef VGA_PAT_BORDER_EN
      if (x == 0 || x == H-1 || y == 0 || y == V-1) return 16'hFFFF;
`endif
      case (mode)
         1:       idx = y / bh;
         2:       return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
         3:       idx = ((x + off) % H) / bw;
         default: idx = x / bw;
      endcase
      if (idx > bn - 1) idx = bn - 1;
      return pal(idx);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one coordinate for one cycle, queue its expectation, and retire
   // the entry whose 2-cycle latency has elapsed.
   task automatic cyc(input int x, input int y, input string tag);
      exp_t e;
      pix_x = 10'(x);
      pix_y = 10'(y);
      e.ea  = ref_pix(x, y, m_mode, m_off, 8);
      e.eb  = ref_pix(x, y, m_mode, m_off, 6);
      e.tag = tag;
      sb.push_back(e);
      @(posedge vga_clk);
      #1;
      if (sb.size() >= 2) begin
         e = sb.pop_front();
         check({e.tag, "/b8"}, pd_a, e.ea);
         check({e.tag, "/b6"}, pd_b, e.eb);
      end
   endtask

   // Last active pixel, then the mode request is presented in the tick cycle.
   task automatic tick_frame(input int new_mode, input bit verbose);
      cyc(H-1, V-1, "last_px");
      if (verbose) check("frame_tick_hi", {15'd0, ft_a}, 16'd1);
      mode_i = 2'(new_mode);
      if (m_mode == 3) m_off = (m_off + STEP) % H;
      m_mode = new_mode;
      cyc(IDLE, IDLE, "blank");
      if (verbose) begin
         check("frame_tick_lo", {15'd0, ft_a}, 16'd0);
         check("cur_mode_b8", {14'd0, cm_a}, 16'(new_mode));
         check("cur_mode_b6", {14'd0, cm_b}, 16'(new_mode));
      end
   endtask

   task automatic drain();
      cyc(IDLE, IDLE, "drain");
      cyc(IDLE, IDLE, "drain");
   endtask

   initial begin
      // Reset state
      #3;
      check("rst_pix", pd_a, 16'h0000);
      check("rst_mode", {14'd0, cm_a}, 16'd0);
      check("rst_tick", {15'd0, ft_b}, 16'd0);
      repeat (3) @(posedge vga_clk);
      #2;
      rst_n = 1'b1;
      @(posedge vga_clk);
      #1;

      // VBAR
      cyc(0, 0, "vbar_x0");
      cyc(80, 0, "vbar_x80");
      cyc(639, 0, "vbar_x639");
      cyc(IDLE, 0, "vbar_xoff");
      cyc(635, 5, "vbar_x635");
      cyc(300, IDLE, "vbar_yoff");
      drain();

      // Mid-frame mode request is held off until the tick
      mode_i = 2'd2;
      cyc(200, 100, "hold_vbar");
      cyc(500, 200, "hold_vbar2");
      check("mode_hold", {14'd0, cm_a}, 16'd0);
      tick_frame(2, 1'b1);

      // CHECK
      cyc(32, 0, "chk_32_0");
      cyc(32, 32, "chk_32_32");
      cyc(0, 100, "chk_0_100");
      cyc(639, 5, "chk_639_5");
      cyc(300, 479, "chk_300_479");
      cyc(0, 0, "chk_0_0");
      cyc(64, 40, "chk_64_40");
      drain();

      // HBAR
      tick_frame(1, 1'b1);
      cyc(5, 1, "hbar_y1");
      cyc(5, 60, "hbar_y60");
      cyc(5, 200, "hbar_y200");
      cyc(5, 479, "hbar_y479");
      drain();

      // SCROLL: entering does not advance; three further ticks give offset 6
      tick_frame(3, 1'b1);
      for (int i = 0; i < 3; i++) tick_frame(3, 1'b0);
      cyc(74, 10, "scr_off6_x74");
      cyc(639, 10, "scr_off6_x639");
      cyc(634, 10, "scr_off6_x634");
      drain();

      // Asynchronous reset mid-frame in SCROLL
      cyc(100, 200, "pre_rst");
      cyc(H-1, V-1, "pre_rst_last");
      check("pre_rst_tick", {15'd0, ft_a}, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_pix8", pd_a, 16'h0000);
      check("async_rst_pix6", pd_b, 16'h0000);
      check("async_rst_tick", {15'd0, ft_a}, 16'd0);
      check("async_rst_mode", {14'd0, cm_a}, 16'd0);
      sb.delete();
      m_mode = 0;
      m_off  = 0;
      mode_i = 2'd0;
      pix_x  = 10'h3FF;
      pix_y  = 10'h3FF;
      repeat (2) @(posedge vga_clk);
      #2;
      rst_n = 1'b1;
      @(posedge vga_clk);
      #1;
      cyc(74, 10, "post_rst_vbar");
      cyc(100, 10, "post_rst_vbar2");
      drain();

      // Re-enter SCROLL: offset restarts at 0, then wraps after 320 ticks
      tick_frame(3, 1'b1);
      cyc(74, 10, "scr_off0_x74");
      drain();
      for (int i = 0; i < 3; i++) tick_frame(3, 1'b0);
      cyc(74, 10, "scr_again6_x74");
      drain();
      for (int i = 0; i < 317; i++) tick_frame(3, 1'b0);
      cyc(74, 10, "scr_wrap_x74");
      cyc(600, 10, "scr_wrap_x600");
      drain();

      // Leaving SCROLL holds the offset; returning resumes from it
      tick_frame(0, 1'b1);
      tick_frame(0, 1'b0);
      tick_frame(3, 1'b1);
      cyc(78, 10, "scr_resume_x78");
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
